// File: rtl/fncode_rr_arbiter_if.sv
// Handshake bundle between the request lines, the round-robin arbiter and
// the 8-to-3 opcode encoder stage that consumes the one-hot function code.
interface fncode_rr_arbiter_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic [N-1:0]     req;
  logic [N-1:0]     fncode;
  logic             fncode_valid;
  logic             fncode_ready;
  logic [N-1:0]     ack;
  logic [CNT_W-1:0] accept_count;

  // Arbiter side: consumes requests and ready, produces code, acks and count.
  modport master (
    input  req,
    input  fncode_ready,
    output fncode,
    output fncode_valid,
    output ack,
    output accept_count
  );

  // Requester/encoder side: the mirror image of the arbiter.
  modport slave (
    output req,
    output fncode_ready,
    input  fncode,
    input  fncode_valid,
    input  ack,
    input  accept_count
  );
endinterface

// File: rtl/fncode_rr_arbiter.sv
// Round-robin arbiter: picks one of eight level requests, offers it as a
// registered one-hot function code under valid/ready, and rotates priority
// to just past the granted index after every accepted code.
module fncode_rr_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fncode_rr_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_reg;
  logic [N-1:0]     fncode_reg;
  logic             valid_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_next;
  logic [N-1:0]     cand_next;
  logic [N-1:0]     grant_idle;
  logic [N-1:0]     grant_next;

  // First set bit of cand scanning start, start+1, ... with modulo-N wrap.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] cand,
                                           input logic [PTR_W-1:0] start);
    logic [N-1:0]     g;
    logic             found;
    logic [PTR_W-1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = start + PTR_W'(k);
      if (!found && cand[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Index of the single set bit of a one-hot vector.
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) idx = idx | PTR_W'(k);
    end
    return idx;
  endfunction

  // Next-grant computation: fresh grant from IDLE, and the back-to-back grant
  // after an accept with the just-acked requester masked out.
  always_comb begin
    accept     = valid_reg & bus.fncode_ready;
    grant_idx  = onehot_idx(fncode_reg);
    ptr_next   = grant_idx + PTR_W'(1);
    cand_next  = bus.req & ~fncode_reg;
    grant_idle = rr_pick(bus.req, ptr_reg);
    grant_next = rr_pick(cand_next, ptr_next);
  end

  // Offer/accept state machine with registered code, valid, pointer and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      fncode_reg <= '0;
      valid_reg  <= 1'b0;
      ptr_reg    <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req != '0) begin
            fncode_reg <= grant_idle;
            valid_reg  <= 1'b1;
            state_reg  <= OFFER;
          end
        end
        OFFER: begin
          // Code is held untouched until the encoder takes it.
          if (accept) begin
            count_reg <= count_reg + CNT_W'(1);
            ptr_reg   <= ptr_next;
            if (cand_next != '0) begin
              fncode_reg <= grant_next;
            end else begin
              fncode_reg <= '0;
              valid_reg  <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
        default: begin
          fncode_reg <= '0;
          valid_reg  <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  // Per-bit acknowledge: only the offered bit, only in the accepting cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ack
      assign bus.ack[gi] = fncode_reg[gi] & valid_reg & bus.fncode_ready;
    end
  endgenerate

  assign bus.fncode       = fncode_reg;
  assign bus.fncode_valid = valid_reg;
  assign bus.accept_count = count_reg;

endmodule
